// File: rtl/seq_divider16.sv
// Sequential 16-bit unsigned restoring divider with a start/busy/done handshake.
// Performs one trial subtraction per clock through the hs16b subtractor.

module hs16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s,
    output logic        cout
);
    // Ripple subtractor a + ~b + 1; the final carry high means no borrow.
    logic [16:0] carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bit
            assign s[gi]       = a[gi] ^ ~b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & ~b[gi]) | (a[gi] & carry[gi]) | (~b[gi] & carry[gi]);
        end
    endgenerate

    assign cout = carry[16];
endmodule

module seq_divider16 #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIVZ
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [WIDTH-1:0] y_reg, y_next;
    logic [WIDTH-1:0] p_reg, p_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             divz_reg, divz_next;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic             accept;
    logic [WIDTH-1:0] d_shifted;
    logic [WIDTH-1:0] p_iter;

    assign trial = {p_reg, d_reg[WIDTH-1]};

    hs16b u_sub (
        .a    (trial[WIDTH-1:0]),
        .b    (y_reg),
        .s    (diff),
        .cout (no_borrow)
    );

    // A set bit 16 means the trial remainder exceeds any 16-bit divisor, and
    // the truncated difference is still exact because trial < 2*divisor.
    assign accept    = trial[WIDTH] | no_borrow;
    assign d_shifted = {d_reg[WIDTH-2:0], accept};
    assign p_iter    = accept ? diff : trial[WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        d_next     = d_reg;
        y_next     = y_reg;
        p_next     = p_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        divz_next  = divz_reg;

        case (state_reg)
            IDLE: begin
                if (START) begin
                    if (B != '0) begin
                        d_next     = A;
                        y_next     = B;
                        p_next     = '0;
                        cnt_next   = CNT_W'(WIDTH);
                        state_next = RUN;
                    end else begin
                        q_next     = '1;
                        r_next     = A;
                        divz_next  = 1'b1;
                        state_next = FIN;
                    end
                end
            end
            RUN: begin
                d_next   = d_shifted;
                p_next   = p_iter;
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    q_next     = d_shifted;
                    r_next     = p_iter;
                    divz_next  = 1'b0;
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_reg <= IDLE;
            d_reg     <= '0;
            y_reg     <= '0;
            p_reg     <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            divz_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            d_reg     <= d_next;
            y_reg     <= y_next;
            p_reg     <= p_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            divz_reg  <= divz_next;
        end
    end

    assign Q    = q_reg;
    assign R    = r_reg;
    assign DIVZ = divz_reg;
    assign BUSY = (state_reg == RUN);
    assign DONE = (state_reg == FIN);
endmodule

// File: tb/tb_seq_divider16.sv
// Directed bench for seq_divider16: latency, results, divide-by-zero,
// ignored START, mid-run reset and a short sweep checked against A/B, A%B.

module tb_seq_divider16;
    logic        CLK = 1'b0;
    logic        nRESET;
    logic        START;
    logic [15:0] A, B;
    logic [15:0] Q, R;
    logic        BUSY, DONE, DIVZ;

    int total = 0;
    int bad   = 0;

    seq_divider16 #(.WIDTH(16)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .START  (START),
        .A      (A),
        .B      (B),
        .Q      (Q),
        .R      (R),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .DIVZ   (DIVZ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called just after the accepting edge; returns edges until DONE, or -1.
    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int i = 0; i <= limit; i++) begin
            if (DONE === 1'b1) begin
                lat = i;
                break;
            end
            if (i < limit) tick();
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        A = a;
        B = b;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Full division with exact latency, handshake and result checks.
    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eq, input logic [15:0] er, input string tag);
        int lat;
        issue(a, b);
        if (b != 16'd0) begin
            chk({tag, "_busy_start"}, {30'd0, BUSY, DONE}, 32'b10);
            for (int i = 1; i < 16; i++) begin
                tick();
                chk({tag, "_busy_run"}, {30'd0, BUSY, DONE}, 32'b10);
            end
            tick();
            chk({tag, "_done_k16"}, {30'd0, BUSY, DONE}, 32'b01);
        end else begin
            wait_done(2, lat);
            chk({tag, "_divz_done"}, {31'd0, (lat == 0 || lat == 1)}, 32'd1);
        end
        chk({tag, "_q"}, {16'd0, Q}, {16'd0, eq});
        chk({tag, "_r"}, {16'd0, R}, {16'd0, er});
        chk({tag, "_divz"}, {31'd0, DIVZ}, {31'd0, (b == 16'd0)});
        $display("div a=%0d b=%0d q=%0d r=%0d divz=%0b", a, b, Q, R, DIVZ);
        tick();
        chk({tag, "_done_pulse"}, {30'd0, BUSY, DONE}, 32'b00);
    endtask

    initial begin
        int lat;
        logic [15:0] ra, rb;
        int no_done;

        nRESET = 1'b0;
        START  = 1'b0;
        A      = 16'd0;
        B      = 16'd0;
        tick();
        tick();
        chk("reset_q", {16'd0, Q}, 32'd0);
        chk("reset_r", {16'd0, R}, 32'd0);
        chk("reset_flags", {29'd0, BUSY, DONE, DIVZ}, 32'd0);
        nRESET = 1'b1;
        tick();

        run_div(16'd1000, 16'd7, 16'd142, 16'd6, "d1000_7");
        run_div(16'hFFFF, 16'h8000, 16'd1, 16'h7FFF, "dffff_8000");
        run_div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, "dffff_1");
        run_div(16'd5, 16'd9, 16'd0, 16'd5, "d5_9");
        run_div(16'd1234, 16'd0, 16'hFFFF, 16'd1234, "d1234_0");
        run_div(16'd300, 16'd300, 16'd1, 16'd0, "d300_300");
        run_div(16'hFFFE, 16'hFFFF, 16'd0, 16'hFFFE, "dfffe_ffff");
        run_div(16'hC000, 16'h8001, 16'd1, 16'h3FFF, "dc000_8001");
        run_div(16'd0, 16'd5, 16'd0, 16'd0, "d0_5");

        // START while busy must be ignored.
        issue(16'd1000, 16'd7);
        tick(); tick(); tick(); tick();
        A = 16'd9; B = 16'd3; START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(20, lat);
        chk("ignore_lat", lat, 32'd11);
        chk("ignore_q", {16'd0, Q}, 32'd142);
        chk("ignore_r", {16'd0, R}, 32'd6);
        $display("div a=1000 b=7 (second start ignored) q=%0d r=%0d", Q, R);
        tick();
        // START issued in the cycle right after DONE.
        run_div(16'd9, 16'd3, 16'd3, 16'd0, "after_done");

        // Reset at iteration 8 abandons the division.
        issue(16'd5000, 16'd13);
        for (int i = 0; i < 7; i++) tick();
        nRESET = 1'b0;
        tick();
        chk("midrst_q", {16'd0, Q}, 32'd0);
        chk("midrst_r", {16'd0, R}, 32'd0);
        chk("midrst_flags", {29'd0, BUSY, DONE, DIVZ}, 32'd0);
        nRESET = 1'b1;
        no_done = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (DONE !== 1'b0 || BUSY !== 1'b0) no_done = 0;
        end
        chk("midrst_no_done", no_done, 32'd1);
        $display("div a=5000 b=13 abandoned by reset");
        run_div(16'd5000, 16'd13, 16'd384, 16'd8, "post_rst");

        // Short sweep against the language's own division.
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case (n % 8)
                0: rb = 16'd0;
                1: rb = 16'd1;
                2: rb = ra;
                3: rb = ra | 16'h8000;
                4: rb = 16'($urandom_range(1, 15));
                default: ;
            endcase
            if (rb == 16'd0)
                run_div(ra, rb, 16'hFFFF, ra, "sweep");
            else
                run_div(ra, rb, ra / rb, ra % rb, "sweep");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
